// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-detects and latches external interrupt lines,
// masks them, and picks a winner by fixed priority (index 0 highest).
// Drives int_sig and a vector to the control unit and holds the EPC for RFE.
module interrupt_controller #(
    parameter int unsigned N_SRC      = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  irq_in,
    input  logic              mask_wr,
    input  logic [N_SRC-1:0]  mask_data,
    input  logic              int_ack,
    input  logic              int_return,
    input  logic [31:0]       pc_in,
    output logic              int_sig,
    output logic [31:0]       int_vector,
    output logic [2:0]        int_id,
    output logic [31:0]       epc,
    output logic [N_SRC-1:0]  pending
);

    localparam int unsigned ID_W = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SVC  = 2'd2
    } state_e;

    state_e              state_q;
    logic                int_sig_q;
    logic [ID_W-1:0]     int_id_q;
    logic [31:0]         int_vector_q;
    logic [31:0]         epc_q;
    logic [N_SRC-1:0]    pending_q;
    logic [N_SRC-1:0]    pending_d;
    logic [N_SRC-1:0]    mask_q;
    logic [N_SRC-1:0]    irq_prev_q;

    logic [N_SRC-1:0]    edge_c;
    logic [N_SRC-1:0]    req_c;
    logic [N_SRC-1:0]    clr_c;
    logic [ID_W-1:0]     winner_c;
    logic                ack_c;

    assign edge_c = irq_in & ~irq_prev_q;
    assign req_c  = pending_q & ~mask_q;
    assign ack_c  = (state_q == S_REQ) && int_ack;

    // Lowest set index among unmasked pending sources wins
    always_comb begin
        logic found;
        winner_c = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (req_c[i] && !found) begin
                winner_c = ID_W'(i);
                found    = 1'b1;
            end
        end
    end

    // Pending update: acknowledge clears the granted bit, a fresh edge on the same cycle wins
    always_comb begin
        clr_c = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (ack_c && (int_id_q == ID_W'(i))) begin
                clr_c[i] = 1'b1;
            end
        end
        pending_d = (pending_q & ~clr_c) | edge_c;
    end

    // Edge-detect history, pending latch and mask register
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
        end else begin
            irq_prev_q <= irq_in;
            pending_q  <= pending_d;
            if (mask_wr) begin
                mask_q <= mask_data;
            end
        end
    end

    // Request/service FSM with registered grant, vector, int_sig and EPC
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            int_sig_q    <= 1'b0;
            int_id_q     <= '0;
            int_vector_q <= VEC_BASE;
            epc_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_c != '0) begin
                        state_q      <= S_REQ;
                        int_sig_q    <= 1'b1;
                        int_id_q     <= winner_c;
                        int_vector_q <= VEC_BASE + (32'(winner_c) * VEC_STRIDE);
                    end
                end
                S_REQ: begin
                    if (int_ack) begin
                        state_q   <= S_SVC;
                        int_sig_q <= 1'b0;
                        epc_q     <= pc_in;
                    end
                end
                S_SVC: begin
                    if (int_return) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    int_sig_q <= 1'b0;
                end
            endcase
        end
    end

    assign int_sig    = int_sig_q;
    assign int_id     = int_id_q;
    assign int_vector = int_vector_q;
    assign epc        = epc_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with a grant scoreboard.
module tb_interrupt_controller;

    localparam int unsigned N_SRC = 4;

    logic              clk;
    logic              rst;
    logic [N_SRC-1:0]  irq_in;
    logic              mask_wr;
    logic [N_SRC-1:0]  mask_data;
    logic              int_ack;
    logic              int_return;
    logic [31:0]       pc_in;
    logic              int_sig;
    logic [31:0]       int_vector;
    logic [2:0]        int_id;
    logic [31:0]       epc;
    logic [N_SRC-1:0]  pending;

    typedef struct {
        logic [2:0]  id;
        logic [31:0] vec;
    } grant_t;

    grant_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     grants_seen;

    interrupt_controller #(
        .N_SRC      (N_SRC),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (32'h0000_0010)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .int_ack    (int_ack),
        .int_return (int_return),
        .pc_in      (pc_in),
        .int_sig    (int_sig),
        .int_vector (int_vector),
        .int_id     (int_id),
        .epc        (epc),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_grant(input logic [2:0] id);
        grant_t g;
        g.id  = id;
        g.vec = 32'h100 + 32'(id) * 32'h10;
        exp_q.push_back(g);
    endtask

    // Grant must be visible now; pop the oldest expected grant and compare
    task automatic check_grant(input string tag);
        grant_t g;
        chk({tag, "_sig"}, 32'(int_sig), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            g = exp_q.pop_front();
            chk({tag, "_id"}, 32'(int_id), 32'(g.id));
            chk({tag, "_vec"}, int_vector, g.vec);
        end
    endtask

    task automatic do_ack(input logic [31:0] pc);
        int_ack = 1'b1;
        pc_in   = pc;
        step();
        int_ack = 1'b0;
    endtask

    task automatic do_return();
        int_return = 1'b1;
        step();
        int_return = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        irq_in     = '0;
        mask_wr    = 1'b0;
        mask_data  = '0;
        int_ack    = 1'b0;
        int_return = 1'b0;
        pc_in      = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_sig", 32'(int_sig), 32'd0);
        chk("rst_id", 32'(int_id), 32'd0);
        chk("rst_vec", int_vector, 32'h100);
        chk("rst_epc", epc, 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);

        // 1: single source, latency and vector
        irq_in = 4'b0100;
        push_grant(3'd2);
        step();
        chk("t1_pend", 32'(pending), 32'h4);
        chk("t1_sig_early", 32'(int_sig), 32'd0);
        step();
        check_grant("t1");
        do_ack(32'h1000);
        chk("t1_ack_sig", 32'(int_sig), 32'd0);
        chk("t1_epc", epc, 32'h1000);
        chk("t1_pend_clr", 32'(pending), 32'd0);
        do_return();
        step();
        chk("t1_held_no_req", 32'(int_sig), 32'd0);
        irq_in = '0;
        step();

        // 2: two sources same cycle, priority then back-to-back
        irq_in = 4'b1010;
        push_grant(3'd1);
        push_grant(3'd3);
        step();
        chk("t2_pend", 32'(pending), 32'hA);
        irq_in = '0;
        step();
        check_grant("t2a");
        do_ack(32'h2000);
        chk("t2_pend_after_ack", 32'(pending), 32'h8);
        do_return();
        chk("t2_idle_sig", 32'(int_sig), 32'd0);
        step();
        check_grant("t2b");
        do_ack(32'h2004);
        do_return();
        step();

        // 3: masked source latches but does not request until unmasked
        mask_wr   = 1'b1;
        mask_data = 4'b0001;
        step();
        mask_wr = 1'b0;
        irq_in  = 4'b0001;
        step();
        chk("t3_pend", 32'(pending), 32'h1);
        step();
        step();
        chk("t3_masked_sig", 32'(int_sig), 32'd0);
        mask_wr   = 1'b1;
        mask_data = 4'b0000;
        push_grant(3'd0);
        step();
        mask_wr = 1'b0;
        step();
        check_grant("t3");
        do_ack(32'h3000);
        do_return();
        irq_in = '0;
        step();

        // 4: no preemption, ack+return together is ack only, EPC capture
        irq_in = 4'b0100;
        push_grant(3'd2);
        step();
        step();
        check_grant("t4a");
        irq_in = 4'b0101;
        step();
        chk("t4_no_preempt_id", 32'(int_id), 32'd2);
        chk("t4_pend_both", 32'(pending), 32'h5);
        int_return = 1'b1;
        do_ack(32'h40);
        int_return = 1'b0;
        chk("t4_epc", epc, 32'h40);
        chk("t4_pend", 32'(pending), 32'h1);
        chk("t4_svc_sig", 32'(int_sig), 32'd0);
        step();
        step();
        chk("t4_svc_hold", 32'(int_sig), 32'd0);
        push_grant(3'd0);
        do_return();
        step();
        check_grant("t4b");
        // new edge on the granted bit during ack keeps it pending
        irq_in = 4'b0000;
        step();
        irq_in = 4'b0001;
        do_ack(32'h44);
        chk("t4_set_wins", 32'(pending), 32'h1);
        push_grant(3'd0);
        do_return();
        step();
        check_grant("t4c");
        do_ack(32'h48);
        do_return();
        irq_in = '0;
        step();
        chk("t4_clean", 32'(pending), 32'd0);

        // 5: spurious ack/return in IDLE, then a held level requests once
        int_ack    = 1'b1;
        int_return = 1'b1;
        pc_in      = 32'hDEAD;
        step();
        int_ack    = 1'b0;
        int_return = 1'b0;
        step();
        chk("t5_spur_sig", 32'(int_sig), 32'd0);
        chk("t5_spur_epc", epc, 32'h48);
        irq_in = 4'b0010;
        push_grant(3'd1);
        step();
        step();
        check_grant("t5");
        do_ack(32'h50);
        do_return();
        grants_seen = 0;
        for (int i = 0; i < 18; i++) begin
            step();
            if (int_sig) grants_seen++;
        end
        chk("t5_one_req", 32'(grants_seen), 32'd0);
        chk("t5_pend", 32'(pending), 32'd0);
        irq_in = '0;
        step();

        // 6: reset from SVC with pending sources
        irq_in = 4'b0010;
        push_grant(3'd1);
        step();
        step();
        check_grant("t6");
        irq_in = 4'b1011;
        step();
        do_ack(32'h60);
        chk("t6_pend_svc", 32'(pending), 32'h9);
        rst    = 1'b1;
        irq_in = '0;
        step();
        rst = 1'b0;
        chk("t6_rst_sig", 32'(int_sig), 32'd0);
        chk("t6_rst_id", 32'(int_id), 32'd0);
        chk("t6_rst_vec", int_vector, 32'h100);
        chk("t6_rst_epc", epc, 32'd0);
        chk("t6_rst_pend", 32'(pending), 32'd0);
        step();
        chk("t6_post_sig", 32'(int_sig), 32'd0);
        chk("t6_sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
